ds1302_write: RTL and testbench

- Serial writer for the DS1302 RTC 3-wire interface; the write-side counterpart of the existing time-read path.
- On a start request it latches BCD hour/minute, unlocks write-protect, writes seconds=00, minute and hour, then re-locks write-protect.
- It sits between the time-set UI logic and the DS1302 pins. The top level owns the IO tristate and arbitrates the pins with the reader.

---
 rtl/ds1302_pkg.sv | 39 +++
 rtl/ds1302_frame_tx.sv | 137 +++++++++++++
 rtl/ds1302_write.sv | 107 ++++++++++
 tb/tb_ds1302_write.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ds1302_pkg.sv
// Shared constants, FSM state type and frame builder for the DS1302 write path.
// Frames are stored in transmit order: bit 0 is the first bit on the wire.
package ds1302_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [7:0] CMD_WP     = 8'h8E;
    localparam logic [7:0] CMD_SEC_W  = 8'h80;
    localparam logic [7:0] CMD_MIN_W  = 8'h82;
    localparam logic [7:0] CMD_HOUR_W = 8'h84;
    localparam logic [7:0] WP_ON      = 8'h80;
    localparam logic [7:0] WP_OFF     = 8'h00;
    localparam logic [7:0] SEC_ZERO   = 8'h00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } tx_state_e;

    // Command byte goes out first, so it occupies the low byte.
    function automatic logic [FRAME_BITS-1:0] frame_word(
        input logic [2:0] idx,
        input logic [7:0] hour,
        input logic [7:0] min
    );
        case (idx)
            3'd0:    frame_word = {WP_OFF, CMD_WP};
            3'd1:    frame_word = {SEC_ZERO, CMD_SEC_W};
            3'd2:    frame_word = {min, CMD_MIN_W};
            3'd3:    frame_word = {hour, CMD_HOUR_W};
            3'd4:    frame_word = {WP_ON, CMD_WP};
            default: frame_word = {WP_ON, CMD_WP};
        endcase
    endfunction

endpackage

// File: rtl/ds1302_frame_tx.sv
// Sends one 16-bit DS1302 frame LSB first: CE setup, 32 SCLK half-periods,
// hold, then CE-low gap. A new frame may be chained directly at gap end.
module ds1302_frame_tx
    import ds1302_pkg::*;
#(
    parameter int SETUP_TICKS = 2,
    parameter int GAP_TICKS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  frame_start_i,
    input  logic [FRAME_BITS-1:0] frame_data_i,
    output logic                  ce_o,
    output logic                  sclk_o,
    output logic                  io_out_o,
    output logic                  io_oe_o,
    output logic                  frame_end_o
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_TICKS - 1);

    tx_state_e             state_q;
    logic [FRAME_BITS-1:0] data_q;
    logic [3:0]            bit_q;
    logic                  half_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ce_q;
    logic                  sclk_q;
    logic                  io_out_q;
    logic                  io_oe_q;

    assign ce_o     = ce_q;
    assign sclk_o   = sclk_q;
    assign io_out_o = io_out_q;
    assign io_oe_o  = io_oe_q;

    // Strobe on the tick that closes the CE-low gap; lets the sequencer chain the next frame.
    assign frame_end_o = (state_q == GAP) && tick && (cnt_q == GAP_LAST);

    // Frame FSM with registered pin outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            bit_q    <= 4'd0;
            half_q   <= 1'b0;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            sclk_q   <= 1'b0;
            io_out_q <= 1'b0;
            io_oe_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_start_i) begin
                        data_q   <= frame_data_i;
                        cnt_q    <= '0;
                        ce_q     <= 1'b1;
                        io_oe_q  <= 1'b1;
                        sclk_q   <= 1'b0;
                        io_out_q <= frame_data_i[0];
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        if (cnt_q == SETUP_LAST) begin
                            cnt_q   <= '0;
                            bit_q   <= 4'd0;
                            half_q  <= 1'b0;
                            state_q <= SHIFT;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!half_q) begin
                            half_q <= 1'b1;
                            sclk_q <= 1'b1;
                        end else begin
                            half_q <= 1'b0;
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                state_q <= HOLD;
                            end else begin
                                // Data moves on the falling edge, away from the DS1302 sample edge.
                                bit_q    <= bit_q + 4'd1;
                                io_out_q <= data_q[bit_q + 4'd1];
                            end
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        ce_q     <= 1'b0;
                        io_oe_q  <= 1'b0;
                        io_out_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (cnt_q == GAP_LAST) begin
                            if (frame_start_i) begin
                                data_q   <= frame_data_i;
                                cnt_q    <= '0;
                                ce_q     <= 1'b1;
                                io_oe_q  <= 1'b1;
                                sclk_q   <= 1'b0;
                                io_out_q <= frame_data_i[0];
                                state_q  <= SETUP;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ce_q     <= 1'b0;
                    sclk_q   <= 1'b0;
                    io_out_q <= 1'b0;
                    io_oe_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ds1302_write.sv
// DS1302 time writer: latches BCD hour/minute and sends the five-frame
// WP-off / seconds / minute / hour / WP-on sequence.
module ds1302_write
    import ds1302_pkg::*;
#(
    parameter int SETUP_TICKS = 2,
    parameter int GAP_TICKS   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [7:0] hourData,
    input  logic [7:0] minData,
    output logic       ce,
    output logic       sclk,
    output logic       io_out,
    output logic       io_oe,
    output logic       busy,
    output logic       done
);

    logic [7:0]            hour_q, hour_d;
    logic [7:0]            min_q, min_d;
    logic [2:0]            idx_q, idx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  frame_start_s;
    logic                  frame_end_s;
    logic [FRAME_BITS-1:0] frame_data_s;
    logic                  unused_bits_s;

    // 12/24-h flag and the minute MSB are masked off, so those input bits are dropped.
    assign unused_bits_s = ^{hourData[7:6], minData[7]};

    assign busy = busy_q;
    assign done = done_q;

    // Frame content follows the next index so a chained frame loads the right word.
    assign frame_data_s = frame_word(idx_d, hour_d, min_d);

    // Sequencer next-state: latch on accepted start, advance index at each frame end.
    always_comb begin
        hour_d        = hour_q;
        min_d         = min_q;
        idx_d         = idx_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        frame_start_s = 1'b0;
        if (!busy_q) begin
            if (start) begin
                hour_d        = {2'b00, hourData[5:0]};
                min_d         = {1'b0, minData[6:0]};
                idx_d         = 3'd0;
                busy_d        = 1'b1;
                frame_start_s = 1'b1;
            end else begin
                idx_d = idx_q;
            end
        end else if (frame_end_s) begin
            if (idx_q < 3'd4) begin
                idx_d         = idx_q + 3'd1;
                frame_start_s = 1'b1;
            end else begin
                idx_d  = 3'd0;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hour_q <= 8'h00;
            min_q  <= 8'h00;
            idx_q  <= 3'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            hour_q <= hour_d;
            min_q  <= min_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    ds1302_frame_tx #(
        .SETUP_TICKS (SETUP_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) u_frame_tx (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .frame_start_i (frame_start_s),
        .frame_data_i  (frame_data_s),
        .ce_o          (ce),
        .sclk_o        (sclk),
        .io_out_o      (io_out),
        .io_oe_o       (io_oe),
        .frame_end_o   (frame_end_s)
    );

endmodule

// File: tb/tb_ds1302_write.sv
// Directed bench for ds1302_write: frame decoder on SCLK rising edges,
// pin-protocol monitor, and sequence timing/latch checks.
module tb_ds1302_write;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [7:0] hourData = 8'h00;
    logic [7:0] minData = 8'h00;
    logic       ce, sclk, io_out, io_oe, busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_mode = 2;     // 0: none, 1: every clk, 2: every 4th clk
    int div = 0;
    int tick_cnt = 0;

    // monitor state
    logic [15:0] rxq[$];
    logic [15:0] rx_word = 16'h0000;
    int   rx_bits = 0;
    int   viol = 0;
    int   done_pulses = 0;
    int   rise_cnt = 0;
    int   fall_cnt = -1000;
    bit   first_pending = 1'b0;
    logic p_ce = 1'b0, p_sclk = 1'b0, p_io = 1'b0, p_done = 1'b0;

    ds1302_write dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start),
        .hourData (hourData),
        .minData  (minData),
        .ce       (ce),
        .sclk     (sclk),
        .io_out   (io_out),
        .io_oe    (io_oe),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Tick generator, driven away from the active edge.
    always @(negedge clk) begin
        if (tick_mode == 1) begin
            tick = 1'b1;
        end else if (tick_mode == 2) begin
            div  = (div == 3) ? 0 : div + 1;
            tick = (div == 3);
        end else begin
            tick = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tick) tick_cnt <= tick_cnt + 1;
    end

    // Protocol monitor and frame decoder.
    always @(negedge clk) begin
        if (sclk && !ce) viol++;
        if (io_oe !== ce) viol++;
        if ((io_out !== p_io) && sclk) viol++;
        if (ce && !p_ce) begin
            if (tick_cnt - fall_cnt < 2) viol++;
            rise_cnt = tick_cnt;
            first_pending = 1'b1;
        end
        if (!ce && p_ce) begin
            fall_cnt = tick_cnt;
            rx_bits = 0;
        end
        if (sclk && !p_sclk) begin
            // the rising edge's own tick is included, so 2 setup ticks give 3
            if (first_pending && (tick_cnt - rise_cnt < 3)) viol++;
            first_pending = 1'b0;
            if (rx_bits < 8) rx_word[8 + rx_bits] = io_out;
            else             rx_word[rx_bits - 8] = io_out;
            rx_bits++;
            if (rx_bits == 16) begin
                rxq.push_back(rx_word);
                rx_bits = 0;
            end
        end
        if (done) done_pulses++;
        if (done && p_done) viol++;
        p_ce = ce; p_sclk = sclk; p_io = io_out; p_done = done;
    end

    task automatic run_seq(input string tag, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] exp_h, input logic [7:0] exp_m,
                           input bit inject, input bit check_clks);
        logic [15:0] exp_f[5];
        int base_q, base_d, base_v, cyc, t0, inj;
        bit seen;
        exp_f[0] = 16'h8E00;
        exp_f[1] = 16'h8000;
        exp_f[2] = {8'h82, exp_m};
        exp_f[3] = {8'h84, exp_h};
        exp_f[4] = 16'h8E80;
        base_q = rxq.size();
        base_d = done_pulses;
        base_v = viol;
        cyc = 0; t0 = 0; inj = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1; hourData = h; minData = m;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                t0 = tick_cnt;
                check_eq({tag, "_busy_start"}, busy, 1'b1);
            end
            if (inj == 1) begin
                start = 1'b0;
                inj = 2;
            end
            if (inject && inj == 0 && (tick_cnt - t0) >= 50) begin
                start = 1'b1; hourData = 8'h11; minData = 8'h11;
                inj = 1;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1'b1);
        check_eq({tag, "_ticks"}, tick_cnt - t0, 185);
        if (check_clks) check_eq({tag, "_clks"}, cyc - 1, 185);
        check_eq({tag, "_busy_end"}, busy, 1'b0);
        repeat (20) @(negedge clk);
        check_eq({tag, "_done_cnt"}, done_pulses - base_d, 1);
        check_eq({tag, "_nframes"}, rxq.size() - base_q, 5);
        for (int i = 0; i < 5; i++) begin
            if (rxq.size() > base_q + i) check_eq({tag, "_frame"}, rxq[base_q + i], exp_f[i]);
            else                         check_eq({tag, "_frame"}, 32'hDEAD, exp_f[i]);
        end
        check_eq({tag, "_viol"}, viol - base_v, 0);
    endtask

    initial begin
        int base_q;
        bit reached;
        rst = 1'b0;
        tick_mode = 2;
        repeat (3) @(negedge clk);
        check_eq("rst_ce", ce, 1'b0);
        check_eq("rst_sclk", sclk, 1'b0);
        check_eq("rst_io_out", io_out, 1'b0);
        check_eq("rst_io_oe", io_oe, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Abort mid-frame idx2 with reset.
        base_q = rxq.size();
        start = 1'b1; hourData = 8'h23; minData = 8'h59;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if ((rxq.size() - base_q) >= 2 && rx_bits >= 5) begin
                reached = 1'b1;
                break;
            end
        end
        check_eq("abort_reach", reached, 1'b1);
        check_eq("abort_pre_f0", (rxq.size() > base_q) ? rxq[base_q] : 16'hDEAD, 16'h8E00);
        check_eq("abort_pre_f1", (rxq.size() > base_q + 1) ? rxq[base_q + 1] : 16'hDEAD, 16'h8000);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ce", ce, 1'b0);
        check_eq("abort_sclk", sclk, 1'b0);
        check_eq("abort_io_oe", io_oe, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (16) @(negedge clk);
        check_eq("abort_nframes", rxq.size() - base_q, 2);

        run_seq("seq_basic", 8'h23, 8'h59, 8'h23, 8'h59, 1'b0, 1'b0);
        run_seq("seq_mask", 8'hE3, 8'hD9, 8'h23, 8'h59, 1'b0, 1'b0);
        run_seq("seq_ignore", 8'h23, 8'h59, 8'h23, 8'h59, 1'b1, 1'b0);
        tick_mode = 1;
        repeat (2) @(negedge clk);
        run_seq("seq_fast", 8'h07, 8'h30, 8'h07, 8'h30, 1'b0, 1'b1);
        check_eq("viol_total", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
